// File: rtl/backprop_sched_pkg.sv
// Shared definitions for the backward-pass weight scheduler: FSM states and
// default sizing.
package backprop_sched_pkg;

  localparam int unsigned N_HIDDEN_DEF = 4;
  localparam int unsigned W_W_DEF      = 8;
  localparam int unsigned H_W_DEF      = 10;
  localparam int unsigned TMO_DEF      = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

endpackage

// File: rtl/backprop_sched_if.sv
// Handshake between the scheduler (master) and the shared weight-update unit
// (slave).
interface backprop_sched_if #(
  parameter int unsigned W_W = 8,
  parameter int unsigned H_W = 10
);
  logic           upd_en_o;
  logic           upd_clr_o;
  logic [H_W-1:0] upd_hidden_o;
  logic [W_W-1:0] upd_w_o;
  logic [W_W-1:0] upd_w_i;
  logic           upd_done_i;

  modport master (
    output upd_en_o, upd_clr_o, upd_hidden_o, upd_w_o,
    input  upd_w_i, upd_done_i
  );

  modport slave (
    input  upd_en_o, upd_clr_o, upd_hidden_o, upd_w_o,
    output upd_w_i, upd_done_i
  );
endinterface

// File: rtl/backprop_sched.sv
// Sequences one backward pass over the hidden-to-output weight bank through a
// shared update unit: clear, enable, wait (with timeout), write back per slot.
module backprop_sched
  import backprop_sched_pkg::*;
#(
  parameter int unsigned N_HIDDEN = N_HIDDEN_DEF,
  parameter int unsigned W_W      = W_W_DEF,
  parameter int unsigned H_W      = H_W_DEF,
  parameter int unsigned TMO      = TMO_DEF,
  localparam int unsigned IDX_W   = $clog2(N_HIDDEN)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    wclr_i,
  input  logic [N_HIDDEN*H_W-1:0] hidden_i,
  backprop_sched_if.master        upd,
  output logic [N_HIDDEN*W_W-1:0] weights_o,
  output logic [IDX_W-1:0]        idx_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [3:0]       tmo_cnt;
  logic [W_W-1:0]   bank [N_HIDDEN];
  logic             upd_en;
  logic             upd_clr;

  assign idx_o            = idx;
  assign busy_o           = (state != S_IDLE);
  assign upd.upd_en_o     = upd_en;
  assign upd.upd_clr_o    = upd_clr;
  assign upd.upd_hidden_o = hidden_i[idx*H_W +: H_W];
  assign upd.upd_w_o      = bank[idx];

  always_comb begin
    weights_o = '0;
    for (int unsigned k = 0; k < N_HIDDEN; k++) begin
      weights_o[k*W_W +: W_W] = bank[k];
    end
  end

  // Strobes are registered: each is raised on the edge that enters its state,
  // so it is high for exactly the cycle spent in that state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= S_IDLE;
      idx     <= '0;
      tmo_cnt <= '0;
      err_o   <= 1'b0;
      done_o  <= 1'b0;
      upd_en  <= 1'b0;
      upd_clr <= 1'b0;
      for (int unsigned k = 0; k < N_HIDDEN; k++) bank[k] <= '0;
    end else if (wclr_i) begin
      state   <= S_IDLE;
      idx     <= '0;
      tmo_cnt <= '0;
      done_o  <= 1'b0;
      upd_en  <= 1'b0;
      upd_clr <= 1'b1;
      for (int unsigned k = 0; k < N_HIDDEN; k++) bank[k] <= '0;
    end else begin
      upd_en  <= 1'b0;
      upd_clr <= 1'b0;
      done_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state   <= S_CLEAR;
            idx     <= '0;
            err_o   <= 1'b0;
            upd_clr <= 1'b1;
          end
        end
        S_CLEAR: begin
          state  <= S_ISSUE;
          upd_en <= 1'b1;
        end
        S_ISSUE: begin
          state   <= S_WAIT;
          tmo_cnt <= '0;
        end
        S_WAIT: begin
          if (upd.upd_done_i) begin
            state <= S_WRITE;
          end else if (tmo_cnt == 4'(TMO)) begin
            state <= S_IDLE;
            idx   <= '0;
            err_o <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
          end
        end
        S_WRITE: begin
          bank[idx] <= upd.upd_w_i;
          if (idx == IDX_W'(N_HIDDEN - 1)) begin
            state  <= S_DONE;
            done_o <= 1'b1;
          end else begin
            idx     <= idx + IDX_W'(1);
            state   <= S_CLEAR;
            upd_clr <= 1'b1;
          end
        end
        S_DONE: begin
          idx   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_backprop_sched.sv
// Randomized bench for backprop_sched with a behavioural update-unit model and
// a pass-level reference model of the weight bank.
module tb_backprop_sched;
  import backprop_sched_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned WW = 8;
  localparam int unsigned HW = 10;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            start_i;
  logic            wclr_i;
  logic [N*HW-1:0] hidden_i;
  logic [N*WW-1:0] weights_o;
  logic [1:0]      idx_o;
  logic            busy_o, done_o, err_o;

  backprop_sched_if #(.W_W(WW), .H_W(HW)) u_if ();

  backprop_sched #(.N_HIDDEN(N), .W_W(WW), .H_W(HW), .TMO(15)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .wclr_i    (wclr_i),
    .hidden_i  (hidden_i),
    .upd       (u_if),
    .weights_o (weights_o),
    .idx_o     (idx_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference state: what the bank should hold, and this pass's stimulus
  logic [WW-1:0] model_bank [N];
  logic [WW-1:0] pass_vals  [N];
  logic [HW-1:0] hid_arr    [N];

  // Update-unit model knobs
  int unit_delay      = 1;
  bit unit_hang       = 1'b0;
  bit unit_ignore_clr = 1'b0;
  int pend;

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      u_if.upd_done_i <= 1'b0;
      u_if.upd_w_i    <= '0;
      pend            <= 0;
    end else if (u_if.upd_clr_o && !unit_ignore_clr) begin
      u_if.upd_done_i <= 1'b0;
      pend            <= 0;
    end else if (u_if.upd_en_o && !unit_hang) begin
      u_if.upd_w_i <= pass_vals[idx_o];
      if (unit_delay <= 1) u_if.upd_done_i <= 1'b1;
      else pend <= unit_delay - 1;
    end else if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) u_if.upd_done_i <= 1'b1;
    end
  end

  // Pulse monitor: each enable must follow its own clear and present slot k
  int clr_cnt, en_cnt, done_cnt;

  always @(negedge clk) begin
    if (rst_i) begin
      if (u_if.upd_clr_o) clr_cnt++;
      if (done_o) done_cnt++;
      if (u_if.upd_en_o) begin
        check_val("en_order", 64'(clr_cnt), 64'(en_cnt + 1));
        if (en_cnt < N) begin
          check_val("en_idx", 64'(idx_o), 64'(en_cnt));
          check_val("en_hidden", 64'(u_if.upd_hidden_o), 64'(hid_arr[en_cnt]));
          check_val("en_wcur", 64'(u_if.upd_w_o), 64'(model_bank[en_cnt]));
        end
        en_cnt++;
      end
    end
  end

  function automatic logic [N*WW-1:0] pack_bank(input logic [WW-1:0] b [N]);
    logic [N*WW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r = r | ((N*WW)'(b[k]) << (k * WW));
    return r;
  endfunction

  task automatic setup_pass(input bit rand_vals);
    for (int k = 0; k < N; k++) begin
      if (rand_vals) pass_vals[k] = WW'($urandom_range(1, 255));
      hid_arr[k] = HW'($urandom_range(0, 1023));
      hidden_i[k*HW +: HW] = hid_arr[k];
    end
    clr_cnt  = 0;
    en_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic run_pass(input string tag, input int dly, input int restart_at,
                          input int exp_lat, input bit rand_vals);
    int lat;
    setup_pass(rand_vals);
    unit_delay = dly;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start_i = (k == restart_at);
      if (k == 1) begin
        check_val({tag, "_busy1"}, 64'(busy_o), 64'd1);
        check_val({tag, "_errclr"}, 64'(err_o), 64'd0);
      end
      if (done_o) begin
        lat = k;
        break;
      end
    end
    start_i = 1'b0;
    check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    repeat (4) @(negedge clk);
    check_val({tag, "_weights"}, 64'(weights_o), 64'(pack_bank(pass_vals)));
    check_val({tag, "_ndone"}, 64'(done_cnt), 64'd1);
    check_val({tag, "_nclr"}, 64'(clr_cnt), 64'(N));
    check_val({tag, "_nen"}, 64'(en_cnt), 64'(N));
    check_val({tag, "_idle"}, 64'(busy_o), 64'd0);
    check_val({tag, "_err"}, 64'(err_o), 64'd0);
    for (int k = 0; k < N; k++) model_bank[k] = pass_vals[k];
  endtask

  initial begin
    int tlat;
    bit found;
    rst_i    = 1'b0;
    start_i  = 1'b0;
    wclr_i   = 1'b0;
    hidden_i = '0;
    for (int k = 0; k < N; k++) begin
      model_bank[k] = '0;
      pass_vals[k]  = '0;
      hid_arr[k]    = '0;
    end
    clr_cnt = 0; en_cnt = 0; done_cnt = 0;

    #2;
    check_val("rst_weights", 64'(weights_o), 64'd0);
    check_val("rst_busy", 64'(busy_o), 64'd0);
    check_val("rst_done", 64'(done_o), 64'd0);
    check_val("rst_err", 64'(err_o), 64'd0);
    check_val("rst_en", 64'(u_if.upd_en_o), 64'd0);
    check_val("rst_clr", 64'(u_if.upd_clr_o), 64'd0);
    check_val("rst_idx", 64'(idx_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);

    // Nominal pass with fixed return values
    pass_vals[0] = 8'h11; pass_vals[1] = 8'h22; pass_vals[2] = 8'h33; pass_vals[3] = 8'h44;
    run_pass("nominal", 1, 0, 4*N + 1, 1'b0);
    check_val("nominal_abs", 64'(weights_o), 64'h4433_2211);

    for (int i = 0; i < 3; i++) run_pass("rand", 1, 0, 4*N + 1, 1'b1);

    run_pass("slow", 5, 0, 8*N + 1, 1'b1);

    // start_i re-pulsed mid-pass is ignored
    run_pass("restart", 1, 7, 4*N + 1, 1'b1);

    // Timeout: unit never completes
    setup_pass(1'b1);
    unit_hang = 1'b1;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    tlat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (err_o) begin
        tlat = k;
        break;
      end
    end
    check_val("tmo_window", 64'(tlat >= 16 && tlat <= 20), 64'd1);
    check_val("tmo_idle", 64'(busy_o), 64'd0);
    check_val("tmo_weights", 64'(weights_o), 64'(pack_bank(model_bank)));
    check_val("tmo_nen", 64'(en_cnt), 64'd1);
    repeat (3) @(negedge clk);
    check_val("tmo_sticky", 64'(err_o), 64'd1);
    unit_hang = 1'b0;
    run_pass("recover", 1, 0, 4*N + 1, 1'b1);

    // Asynchronous reset while in ISSUE
    setup_pass(1'b1);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (u_if.upd_en_o) begin
        found = 1'b1;
        break;
      end
    end
    check_val("arst_reach_issue", 64'(found), 64'd1);
    #1 rst_i = 1'b0;
    #1;
    check_val("arst_weights", 64'(weights_o), 64'd0);
    check_val("arst_busy", 64'(busy_o), 64'd0);
    check_val("arst_en", 64'(u_if.upd_en_o), 64'd0);
    check_val("arst_clr", 64'(u_if.upd_clr_o), 64'd0);
    check_val("arst_idx", 64'(idx_o), 64'd0);
    check_val("arst_done", 64'(done_o), 64'd0);
    for (int k = 0; k < N; k++) model_bank[k] = '0;
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    run_pass("post_arst", 1, 0, 4*N + 1, 1'b1);

    // wclr_i while waiting on slot 2; the unit's late done must be ignored
    setup_pass(1'b1);
    unit_delay = 5;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      #1;
      if (en_cnt == 3) begin
        found = 1'b1;
        break;
      end
    end
    check_val("wclr_reach_idx2", 64'(found), 64'd1);
    @(negedge clk);
    check_val("wclr_pre_idx", 64'(idx_o), 64'd2);
    unit_ignore_clr = 1'b1;
    wclr_i = 1'b1;
    @(posedge clk);
    #1 wclr_i = 1'b0;
    @(negedge clk);
    check_val("wclr_weights", 64'(weights_o), 64'd0);
    check_val("wclr_idx", 64'(idx_o), 64'd0);
    check_val("wclr_busy", 64'(busy_o), 64'd0);
    check_val("wclr_clrpulse", 64'(u_if.upd_clr_o), 64'd1);
    repeat (10) @(negedge clk);
    check_val("wclr_late_done_seen", 64'(u_if.upd_done_i), 64'd1);
    check_val("wclr_still_idle", 64'(busy_o), 64'd0);
    check_val("wclr_still_zero", 64'(weights_o), 64'd0);
    check_val("wclr_no_done", 64'(done_cnt), 64'd0);
    unit_ignore_clr = 1'b0;
    for (int k = 0; k < N; k++) model_bank[k] = '0;
    run_pass("post_wclr", 1, 0, 4*N + 1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/backprop_sched.md
BACKPROP_SCHED -- requirements
Module: backprop_sched

Interface
REQ-001 Parameter N_HIDDEN, default 4, number of hidden-to-output weights sequenced (power of two, 2..8).
REQ-002 Parameter W_W, default 8, weight width.
REQ-003 Parameter H_W, default 10, hidden activation width.
REQ-004 Parameter TMO, default 15, WAIT-state timeout in cycles (4-bit counter).
REQ-005 clk_i  in  1  single clock; all state on rising edge.
REQ-006 rst_i  in  1  asynchronous active-low reset.
REQ-007 start_i  in  1  level-sampled request to begin one backward pass (b_pass from the top state machine).
REQ-008 wclr_i  in  1  synchronous clear of the weight bank and abort of any pass.
REQ-009 hidden_i  in  N_HIDDEN*H_W  packed hidden activations; slot k at bits [k*H_W +: H_W].
REQ-010 upd_w_i  in  W_W  updated weight returned by the shared update unit.
REQ-011 upd_done_i  in  1  completion flag from the update unit (sticky until that unit is cleared).
REQ-012 upd_en_o  out  1  one-cycle enable to the update unit.
REQ-013 upd_clr_o  out  1  one-cycle clear to the update unit (drives its zero-weight reset).
REQ-014 upd_hidden_o  out  H_W  hidden value for the current index.
REQ-015 upd_w_o  out  W_W  current stored weight for the current index.
REQ-016 weights_o  out  N_HIDDEN*W_W  packed weight bank, slot k at [k*W_W +: W_W].
REQ-017 idx_o  out  log2(N_HIDDEN)  current index; busy_o, done_o, err_o  out  1 each.

Function
REQ-018 FSM states: IDLE, CLEAR, ISSUE, WAIT, WRITE, DONE.
REQ-019 IDLE: busy_o=0; start_i=1 -> CLEAR with idx=0, err_o cleared.
REQ-020 CLEAR: upd_clr_o=1 for exactly one cycle -> ISSUE.
REQ-021 ISSUE: upd_en_o=1 for exactly one cycle, timeout counter loaded to 0 -> WAIT.
REQ-022 WAIT: upd_done_i=1 -> WRITE; else counter increments; counter==TMO without done -> set err_o, -> IDLE, bank slot unchanged.
REQ-023 WRITE: weight[idx] <= upd_w_i; idx==N_HIDDEN-1 -> DONE, else idx+1 and -> CLEAR.
REQ-024 DONE: done_o=1 for exactly one cycle, idx returns to 0 -> IDLE.
REQ-025 upd_hidden_o and upd_w_o combinationally select slot idx in every state.
REQ-026 busy_o=1 in every state except IDLE.
REQ-027 start_i while busy_o=1 is ignored; no queuing.
REQ-028 Nominal pass latency: start_i sampled at edge 0 -> done_o high 4*N_HIDDEN+1 cycles later with a 1-cycle-responding unit (17 for N_HIDDEN=4).
REQ-029 wclr_i=1: bank cleared to 0, FSM -> IDLE, idx=0, upd_clr_o=1 that cycle; wclr_i has priority over start_i and every state transition.
REQ-030 Weight values pass through unmodified; no arithmetic on upd_w_i.
REQ-031 err_o is sticky until the next accepted start_i or reset.

Reset
REQ-032 rst_i low: state IDLE, idx=0, bank all 0, counter 0, err_o=0, done_o=0, upd_en_o=0, upd_clr_o=0, effective immediately without a clock.
REQ-033 Reset asserted mid-pass discards the pass; no partial write completes after release.

Structure
REQ-034 Shared package holds the FSM state enumeration, N_HIDDEN/W_W/H_W defaults and TMO.
REQ-035 Single flat module; no sub-module. The update unit is instantiated alongside this block at the level above it, not inside it.

Verification
REQ-036 Nominal: N_HIDDEN=4, bank 0, unit model returns 0x11,0x22,0x33,0x44 one cycle after enable -> weights_o=0x44332211, done_o pulses at cycle 17, four upd_clr_o/upd_en_o pulses in order.
REQ-037 Timeout: upd_done_i held 0 after the first enable -> err_o=1 after 15 WAIT cycles, FSM IDLE, weights_o unchanged.
REQ-038 wclr_i asserted while in WAIT for idx=2 -> weights_o=0, idx_o=0, busy_o=0 next cycle; the later upd_done_i is ignored.
REQ-039 start_i re-pulsed during a pass -> exactly one done_o pulse, sequence unaffected.
REQ-040 rst_i low mid-ISSUE -> all outputs at reset values asynchronously; a subsequent start_i completes a full pass normally.
REQ-041 Slow unit, done 5 cycles after enable -> pass completes with done_o at cycle 33 and no err_o.
